// File: rtl/dmem_pkg.sv
// Purpose: shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

  // Responder FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_DUMP,
    ST_DONE
  } dmem_state_t;

  localparam int DEPTH_DEFAULT = 64;
  localparam int IDX_W         = $clog2(DEPTH_DEFAULT);  // word-index width at default depth
  localparam int WAIT_W        = 4;                      // wait-state counter width (0..15)

  // Any nonzero byte offset within a 64-bit word counts as misaligned.
  function automatic logic addr_misaligned(input logic [2:0] byte_off);
    return byte_off != 3'b000;
  endfunction

endpackage

// File: rtl/dmem_store.sv
// Purpose: DEPTH x N register array, synchronous write, combinational read, synchronous clear.
// Latency: write commits at the clock edge; read data is combinational from ridx.
// Backpressure: none; every write is accepted.
// Ports: clk, clr (synchronous clear, overrides write), we/widx/wdata (write port),
//        ridx/rdata (read port).
module dmem_store #(
  parameter int N     = 64,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] ridx,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Purpose: slave end of the core's DM_* port; one access at a time with WAIT wait states, plus memory dump.
// Latency: request-to-DM_ready is WAIT+2 cycles counting the IDLE sample cycle; dump runs DEPTH cycles.
// Backpressure: requests are ignored outside IDLE; the initiator holds its request until DM_ready.
// Ports: clk, reset (sync active-low); DM_addr/DM_writeData/DM_writeEnable/DM_readEnable (request),
//        DM_readData/DM_ready (response), misaligned (sticky), dump/dump_valid/dump_addr/
//        dump_data/dump_done (memory image stream).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int N     = 64,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int WAIT  = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  input  logic         DM_writeEnable,
  input  logic         DM_readEnable,
  output logic [N-1:0] DM_readData,
  output logic         DM_ready,
  output logic         misaligned,
  input  logic         dump,
  output logic         dump_valid,
  output logic [N-1:0] dump_addr,
  output logic [N-1:0] dump_data,
  output logic         dump_done
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_t       state;
  logic [WAIT_W-1:0] cnt;
  logic [AW-1:0]     idx;       // latched request index, or current dump index
  logic [N-1:0]      wdata_q;
  logic              we_q;
  logic              re_q;

  logic              req;
  logic [AW-1:0]     req_idx;
  logic [AW-1:0]     idx_nx;
  logic              unused_addr_hi;

  // Access-path selection: the zero-wait case accesses straight from the inputs.
  logic              acc_now;
  logic              acc_we;
  logic              acc_re;
  logic [AW-1:0]     acc_idx;
  logic [N-1:0]      acc_wdata;
  logic [AW-1:0]     rd_idx;
  logic [N-1:0]      mem_rdata;
  logic [N-1:0]      load_data;

  assign req            = DM_writeEnable | DM_readEnable;
  assign req_idx        = DM_addr[AW+2:3];
  assign idx_nx         = idx + 1'b1;
  assign unused_addr_hi = ^DM_addr[N-1:AW+3];

  always_comb begin
    acc_now   = 1'b0;
    acc_we    = we_q;
    acc_re    = re_q;
    acc_idx   = idx;
    acc_wdata = wdata_q;
    rd_idx    = idx;
    case (state)
      ST_IDLE: begin
        if (req && (WAIT == 0)) begin
          acc_now   = 1'b1;
          acc_we    = DM_writeEnable;
          acc_re    = DM_readEnable;
          acc_idx   = req_idx;
          acc_wdata = DM_writeData;
        end
        // A request reads its own word; otherwise prefetch word 0 for a dump start.
        rd_idx = req ? req_idx : '0;
      end
      ST_WAIT: acc_now = (cnt == WAIT_W'(1));
      ST_DUMP: rd_idx  = idx_nx;
      default: ;
    endcase
  end

  // Write-first: a combined store+load returns the data being stored.
  assign load_data = acc_we ? acc_wdata : mem_rdata;

  dmem_store #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .clk   (clk),
    .clr   (!reset),
    .we    (acc_now & acc_we),
    .widx  (acc_idx),
    .wdata (acc_wdata),
    .ridx  (rd_idx),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx         <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      DM_readData <= '0;
      DM_ready    <= 1'b0;
      misaligned  <= 1'b0;
      dump_valid  <= 1'b0;
      dump_addr   <= '0;
      dump_data   <= '0;
      dump_done   <= 1'b0;
    end else begin
      DM_ready <= 1'b0;
      if (acc_now && acc_re) begin
        DM_readData <= load_data;
      end
      case (state)
        ST_IDLE: begin
          if (req) begin
            idx     <= req_idx;
            wdata_q <= DM_writeData;
            we_q    <= DM_writeEnable;
            re_q    <= DM_readEnable;
            if (addr_misaligned(DM_addr[2:0])) begin
              misaligned <= 1'b1;
            end
            if (acc_now) begin
              DM_ready <= 1'b1;
              state    <= ST_RESP;
            end else begin
              cnt   <= WAIT_W'(WAIT);
              state <= ST_WAIT;
            end
          end else if (dump) begin
            idx        <= '0;
            dump_valid <= 1'b1;
            dump_addr  <= '0;
            dump_data  <= mem_rdata;
            state      <= ST_DUMP;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 1'b1;
          if (acc_now) begin
            DM_ready <= 1'b1;
            state    <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        ST_DUMP: begin
          // The word on the outputs this cycle is idx; stop after DEPTH-1 was shown.
          if (idx == AW'(DEPTH - 1)) begin
            dump_valid <= 1'b0;
            dump_done  <= 1'b1;
            state      <= ST_DONE;
          end else begin
            idx       <= idx_nx;
            dump_addr <= N'(idx_nx) << 3;
            dump_data <= mem_rdata;
          end
        end
        ST_DONE: begin
          if (!dump) begin
            dump_done <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Purpose: directed, table-driven check of dmem_responder at WAIT=2 and WAIT=0.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;            // 0 -> requests go to the WAIT=2 instance, 1 -> WAIT=0 instance
  logic        req_we, req_re, dump;
  logic [63:0] addr, wdata;

  logic [63:0] rd2, da2, ddat2, rd0, da0, ddat0;
  logic        rdy2, mis2, dv2, dd2, rdy0, mis0, dv0, dd0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.N(64), .DEPTH(64), .WAIT(2)) u_w2 (
    .clk(clk), .reset(reset), .DM_addr(addr), .DM_writeData(wdata),
    .DM_writeEnable(req_we & ~sel), .DM_readEnable(req_re & ~sel),
    .DM_readData(rd2), .DM_ready(rdy2), .misaligned(mis2), .dump(dump),
    .dump_valid(dv2), .dump_addr(da2), .dump_data(ddat2), .dump_done(dd2)
  );

  dmem_responder #(.N(64), .DEPTH(64), .WAIT(0)) u_w0 (
    .clk(clk), .reset(reset), .DM_addr(addr), .DM_writeData(wdata),
    .DM_writeEnable(req_we & sel), .DM_readEnable(req_re & sel),
    .DM_readData(rd0), .DM_ready(rdy0), .misaligned(mis0), .dump(1'b0),
    .dump_valid(dv0), .dump_addr(da0), .dump_data(ddat0), .dump_done(dd0)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Issue one request at posedge+1; lat is in cycles counting the sample cycle (-1 on timeout).
  task automatic do_req(input bit s, input bit w, input bit r, input logic [63:0] a,
                        input logic [63:0] d, output logic [63:0] rd, output int lat,
                        output bit mis);
    int  n;
    bit  got;
    sel = s; addr = a; wdata = d; req_we = w; req_re = r;
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      got = s ? rdy0 : rdy2;
    end
    lat = got ? n + 1 : -1;
    rd  = s ? rd0 : rd2;
    mis = s ? mis0 : mis2;
    @(posedge clk); #1;
    req_we = 0; req_re = 0;
    chk("ready_one_cycle", {63'd0, (s ? rdy0 : rdy2)}, 64'd0);
  endtask

  typedef struct {
    bit          s;
    bit          w;
    bit          r;
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] exp_rd;
    int          exp_lat;
    bit          exp_mis;
  } vec_t;

  vec_t vt [15];

  initial begin
    logic [63:0] rd;
    int          lat;
    bit          mis;
    int          k, done_cyc, n;
    bit          rdy_seen;

    vt[0]  = '{0, 1, 0, 64'h10,  64'hDEAD_BEEF, 64'h0,         4, 0};
    vt[1]  = '{0, 0, 1, 64'h10,  64'h0,         64'hDEAD_BEEF, 4, 0};
    vt[2]  = '{1, 1, 0, 64'h0,   64'hA0,        64'h0,         2, 0};
    vt[3]  = '{1, 1, 0, 64'h8,   64'hA1,        64'h0,         2, 0};
    vt[4]  = '{1, 1, 0, 64'h1F8, 64'hA2,        64'h0,         2, 0};
    vt[5]  = '{1, 0, 1, 64'h8,   64'h0,         64'hA1,        2, 0};
    vt[6]  = '{1, 0, 1, 64'h1F8, 64'h0,         64'hA2,        2, 0};
    vt[7]  = '{1, 0, 1, 64'h200, 64'h0,         64'hA0,        2, 0};
    vt[8]  = '{1, 1, 0, 64'h208, 64'hB1,        64'hA0,        2, 0};
    vt[9]  = '{1, 0, 1, 64'h8,   64'h0,         64'hB1,        2, 0};
    vt[10] = '{0, 1, 0, 64'h8,   64'h1111,      64'hDEAD_BEEF, 4, 0};
    vt[11] = '{0, 0, 1, 64'hC,   64'h0,         64'h1111,      4, 1};
    vt[12] = '{0, 0, 1, 64'h10,  64'h0,         64'hDEAD_BEEF, 4, 1};
    vt[13] = '{0, 1, 1, 64'h18,  64'h55,        64'h55,        4, 1};
    vt[14] = '{0, 0, 1, 64'h18,  64'h0,         64'h55,        4, 1};

    reset = 0; sel = 0; req_we = 0; req_re = 0; dump = 0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",    {63'd0, rdy2}, 64'd0);
    chk("rst_rdata",    rd2, 64'd0);
    chk("rst_mis",      {63'd0, mis2}, 64'd0);
    chk("rst_dvalid",   {63'd0, dv2}, 64'd0);
    chk("rst_ddone",    {63'd0, dd2}, 64'd0);
    chk("rst_w0_ready", {63'd0, rdy0}, 64'd0);
    reset = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      do_req(vt[i].s, vt[i].w, vt[i].r, vt[i].a, vt[i].d, rd, lat, mis);
      chk($sformatf("vec%0d_lat", i),   64'(lat), 64'(vt[i].exp_lat));
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_mis", i),   {63'd0, mis}, {63'd0, vt[i].exp_mis});
    end

    // Fill words 0..63 with index*3, then dump with a load arriving mid-dump.
    for (int i = 0; i < 64; i++) begin
      do_req(0, 1, 0, 64'(i * 8), 64'(i * 3), rd, lat, mis);
    end
    sel = 0;
    dump = 1;
    k = 0; done_cyc = -1; rdy_seen = 0;
    for (int c = 0; c < 100 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (c == 5) begin
        addr = 64'h10; req_re = 1;
      end
      if (dv2) begin
        chk("dump_addr", da2, 64'(k * 8));
        chk("dump_data", ddat2, 64'(k * 3));
        k++;
      end
      if (rdy2) rdy_seen = 1;
      if (dd2) done_cyc = c;
    end
    chk("dump_words", 64'(k), 64'd64);
    chk("dump_done_cycle", 64'(done_cyc), 64'd64);
    chk("no_ready_in_dump", {63'd0, rdy_seen}, 64'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("done_held", {63'd0, dd2}, 64'd1);
      chk("no_ready_in_done", {63'd0, rdy2}, 64'd0);
    end
    dump = 0;
    @(posedge clk); #1;
    chk("done_cleared", {63'd0, dd2}, 64'd0);
    chk("dvalid_low", {63'd0, dv2}, 64'd0);
    chk("ready_low_at_idle", {63'd0, rdy2}, 64'd0);
    n = 0;
    while (!rdy2 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("post_dump_load_edges", 64'(n), 64'd3);
    chk("post_dump_load_data", rd2, 64'd6);
    @(posedge clk); #1;
    req_re = 0;
    @(posedge clk); #1;

    // Reset while a store is waiting: store must not commit, all outputs clear.
    sel = 0; addr = 64'h20; wdata = 64'h77; req_we = 1;
    @(posedge clk); #1;
    reset = 0; req_we = 0;
    @(posedge clk); #1;
    reset = 1;
    chk("rst2_ready", {63'd0, rdy2}, 64'd0);
    chk("rst2_rdata", rd2, 64'd0);
    chk("rst2_mis",   {63'd0, mis2}, 64'd0);
    chk("rst2_daddr", da2, 64'd0);
    chk("rst2_ddata", ddat2, 64'd0);
    chk("rst2_ddone", {63'd0, dd2}, 64'd0);
    chk("rst2_w0_rdata", rd0, 64'd0);
    do_req(0, 0, 1, 64'h20, 64'h0, rd, lat, mis);
    chk("rst2_load_abandoned", rd, 64'd0);
    chk("rst2_load_lat", 64'(lat), 64'd4);
    do_req(0, 0, 1, 64'h18, 64'h0, rd, lat, mis);
    chk("rst2_mem_cleared", rd, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
